// File: rtl/axis_pixel_rx.sv
// axis_pixel_rx: AXI4-Stream pixel receiver with skid FIFO, frame counter and TLAST checking.
// Emits one-cycle Valid_out strobes with frame start/done and TLAST error pulses.
module axis_pixel_rx #(
    parameter int DATA_W       = 8,
    parameter int FRAME_PIXELS = 921600,
    parameter int CNT_W        = 20,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic              Clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] S_tdata,
    input  logic              S_tvalid,
    input  logic              S_tlast,
    output logic              S_tready,
    input  logic              Pix_ready,
    output logic              Valid_out,
    output logic [DATA_W-1:0] Data_out,
    output logic              Frame_start,
    output logic              Frame_done,
    output logic              Err_early_last,
    output logic              Err_missing_last,
    output logic              Busy,
    output logic [CNT_W-1:0]  Pix_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [DATA_W:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
    logic [AW:0]         r_count;
    logic                r_tready;
    state_t              r_state;
    logic                r_valid, r_start, r_done, r_early, r_missing;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_pix_count;

    logic                w_wr, w_rd, w_last, w_final, w_end;
    logic [AW:0]         w_count_nxt;
    logic [DATA_W:0]     w_head;
    logic [CNT_W-1:0]    w_idx;

    assign w_wr        = S_tvalid && r_tready;
    assign w_rd        = Pix_ready && (r_count != '0);
    assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    assign w_head      = r_mem[r_rd_ptr];
    assign w_last      = w_head[DATA_W];
    // Index of the pixel being read; IDLE always means pixel 0 of a new frame
    assign w_idx       = (r_state == IDLE) ? '0 : r_pix_count;
    assign w_final     = (w_idx == CNT_W'(FRAME_PIXELS - 1));
    assign w_end       = w_last || w_final;

    always_ff @(posedge Clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {S_tlast, S_tdata};
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_tready <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count  <= w_count_nxt;
            // Ready follows next-cycle occupancy so a full FIFO is never written
            r_tready <= (w_count_nxt != (AW+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pix_count <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_start     <= 1'b0;
            r_done      <= 1'b0;
            r_early     <= 1'b0;
            r_missing   <= 1'b0;
        end else begin
            r_valid   <= w_rd;
            r_start   <= w_rd && (r_state == IDLE);
            r_done    <= w_rd && w_end;
            r_early   <= w_rd && w_last && !w_final;
            r_missing <= w_rd && w_final && !w_last;
            if (w_rd) begin
                r_data      <= w_head[DATA_W-1:0];
                r_pix_count <= w_end ? '0 : w_idx + CNT_W'(1);
                r_state     <= w_end ? IDLE : ACTIVE;
            end
        end
    end

    assign S_tready         = r_tready;
    assign Valid_out        = r_valid;
    assign Data_out         = r_data;
    assign Frame_start      = r_start;
    assign Frame_done       = r_done;
    assign Err_early_last   = r_early;
    assign Err_missing_last = r_missing;
    assign Busy             = (r_state == ACTIVE);
    assign Pix_count        = r_pix_count;
endmodule
